// File: rtl/cfg_sequencer.sv
// cfg_sequencer: shadowed parameter set streamed atomically to config regs; CFG_SEQ_CHECKSUM_EN adds an XOR checksum at idx 6
module cfg_sequencer #(
  parameter int NUM_REGS = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [2:0]  host_idx,
  input  logic [15:0] host_data,
  input  logic        commit,
  input  logic        abort,
  input  logic        emergency,
  output logic        cfg_we,
  output logic [3:0]  cfg_addr,
  output logic [15:0] wght_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);
  typedef enum logic [2:0] {IDLE, CHECK, WAIT_SAFE, WRITE, DONE, ERR} state_t;
  localparam logic [2:0] LAST    = 3'(NUM_REGS - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t      state;
  logic [15:0] shadow [NUM_REGS];
  logic [7:0]  cnt;
  logic        wr, th_ok, sum_ok;
  assign wr    = host_valid && state == IDLE;
  assign th_ok = shadow[4][7:0] < shadow[5][7:0];
`ifdef CFG_SEQ_CHECKSUM_EN
  logic [15:0] csum, sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_REGS; i++) sum = sum ^ shadow[i];
  end
  assign sum_ok = sum == csum;
`else
  assign sum_ok = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
`ifdef CFG_SEQ_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      if (wr && host_idx <= LAST) shadow[host_idx] <= host_data;
`ifdef CFG_SEQ_CHECKSUM_EN
      if (wr && host_idx == 3'd6) csum <= host_data;
`endif
      case (state)
        IDLE: if (commit) begin
          state <= CHECK;
          err   <= 2'b00;
        end
        CHECK: if (!sum_ok) begin
          state <= ERR;
          err   <= 2'b11;
        end else if (!th_ok) begin
          state <= ERR;
          err   <= 2'b01;
        end else begin
          state <= WAIT_SAFE;
          cnt   <= '0;
        end
        // abort outranks both the safe exit and the timeout
        WAIT_SAFE: if (abort) state <= IDLE;
        else if (!emergency) begin
          state <= WRITE;
          cnt   <= '0;
        end else if (cnt == TO_LAST) begin
          state <= ERR;
          err   <= 2'b10;
        end else cnt <= cnt + 8'd1;
        WRITE: if (cnt[2:0] == LAST) state <= DONE;
        else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
  assign host_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign cfg_we     = state == WRITE;
  assign cfg_addr   = cfg_we ? cnt[3:0] : 4'd0;
  assign wght_data  = cfg_we ? shadow[cnt[2:0]] : 16'd0;
endmodule

// File: tb/tb_cfg_sequencer.sv
// tb_cfg_sequencer: table-driven bench for cfg_sequencer plus a reset-mid-burst sequence
module tb_cfg_sequencer;
  logic        clk = 0, rst = 1;
  logic        host_valid = 0, host_ready;
  logic [2:0]  host_idx = 0;
  logic [15:0] host_data = 0;
  logic        commit = 0, abort = 0, emergency = 0;
  logic        cfg_we, busy, done;
  logic [3:0]  cfg_addr;
  logic [15:0] wght_data;
  logic [1:0]  err;
  int          total = 0, passed = 0;
  cfg_sequencer dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_idx(host_idx), .host_data(host_data), .commit(commit), .abort(abort),
    .emergency(emergency), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .wght_data(wght_data), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0][15:0] d;
    int               hold, ef, ab;
    bit               coll, cbad;
    int               ew, efirst, eend, edone;
    logic [1:0]       eerr;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hwrite(input logic [2:0] idx, input logic [15:0] data);
    host_valid = 1;
    host_idx   = idx;
    host_data  = data;
    tick();
    host_valid = 0;
  endtask
  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, wa, em,
                              input int hold, ef, ab, input bit coll, cbad,
                              input int ew, efirst, eend, edone, input logic [1:0] eerr);
    vec_t r;
    r.d = {em, wa, w3, w2, w1, w0};
    r.hold = hold; r.ef = ef; r.ab = ab; r.coll = coll; r.cbad = cbad;
    r.ew = ew; r.efirst = efirst; r.eend = eend; r.edone = edone; r.eerr = eerr;
    return r;
  endfunction
  initial begin
    vec_t             c;
    logic [5:0][15:0] fw;
    logic [15:0]      cs;
    logic [1:0]       prev_err;
    int               nw, first, nd, endk;
    v[0]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 0, 0, 0, 0, 6, 3, 10, 1, 2'b00);
    v[1]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0080, 16'h0040, 0, 0, 0, 0, 0, 0, -1, 3, 0, 2'b01);
    v[2]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 10, 0, 0, 0, 0, 6, 13, 20, 1, 2'b00);
    v[3]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 1, 0, 0, 0, 0, 6, 4, 11, 1, 2'b00);
    v[4]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 4, 0, 0, 0, 6, 3, 10, 1, 2'b00);
    v[5]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 1, 0, 0, 0, 0, -1, 258, 0, 2'b10);
    v[6]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 1, 5, 0, 0, 0, -1, 6, 0, 2'b00);
    v[7]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0040, 0, 0, 0, 0, 0, 0, -1, 3, 0, 2'b01);
    v[8]  = mk(16'h8001, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h017F, 16'hAA80, 0, 0, 0, 0, 0, 6, 3, 10, 1, 2'b00);
    v[9]  = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0030, 0, 0, 0, 1, 0, 6, 3, 10, 1, 2'b00);
    v[10] = mk(16'h1234, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 0, 0, 0, 1, 6, 3, 10, 1, 2'b00);
    v[11] = mk(16'h0005, 16'h00FE, 16'h0010, 16'h0003, 16'h0040, 16'h0080, 0, 0, 2, 0, 0, 0, -1, 3, 0, 2'b00);
    #12;
    chk("rst_host_ready", int'(host_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cfg_we", int'(cfg_we), 0);
    chk("rst_cfg_addr", int'(cfg_addr), 0);
    chk("rst_wght_data", int'(wght_data), 0);
    rst = 0;
    tick();
    prev_err = 2'b00;
    for (int i = 0; i < 12; i++) begin
      c = v[i];
`ifdef CFG_SEQ_CHECKSUM_EN
      if (c.cbad) begin
        c.ew = 0; c.efirst = -1; c.eend = 3; c.edone = 0; c.eerr = 2'b11;
      end
`endif
      chk($sformatf("v%0d_err_held", i), int'(err), int'(prev_err));
      fw = c.d;
      if (c.coll) fw[5] = 16'h00C0;
      cs = fw[0] ^ fw[1] ^ fw[2] ^ fw[3] ^ fw[4] ^ fw[5];
      if (c.cbad) cs = cs ^ 16'h0001;
      for (int j = 0; j < 6; j++) hwrite(3'(j), c.d[j]);
      hwrite(3'd6, cs);
      hwrite(3'd7, 16'hDEAD);
      commit = 1;
      if (c.coll) begin
        host_valid = 1; host_idx = 3'd5; host_data = 16'h00C0;
      end
      tick();
      commit = 0;
      host_valid = 0;
      nw = 0; first = -1; nd = 0; endk = -1;
      for (int k = 1; k <= 400; k++) begin
        emergency = (k >= 2 && k < 2 + c.hold) || (c.ef > 0 && k >= c.ef);
        abort     = k == c.ab;
        if (k == 1) chk($sformatf("v%0d_busy", i), int'(busy), 1);
        if (cfg_we) begin
          if (nw < 6) begin
            chk($sformatf("v%0d_addr%0d", i, nw), int'(cfg_addr), nw);
            chk($sformatf("v%0d_data%0d", i, nw), int'(wght_data), int'(fw[nw]));
          end
          if (first < 0) first = k;
          nw++;
        end
        if (done) nd++;
        if (host_ready) begin
          endk = k;
          break;
        end
        tick();
      end
      emergency = 0;
      abort = 0;
      chk($sformatf("v%0d_writes", i), nw, c.ew);
      chk($sformatf("v%0d_first_we", i), first, c.efirst);
      chk($sformatf("v%0d_idle_cycle", i), endk, c.eend);
      chk($sformatf("v%0d_done_pulses", i), nd, c.edone);
      chk($sformatf("v%0d_err", i), int'(err), int'(c.eerr));
      prev_err = c.eerr;
      tick();
    end
    for (int j = 0; j < 6; j++) hwrite(3'(j), v[0].d[j]);
    hwrite(3'd6, v[0].d[0] ^ v[0].d[1] ^ v[0].d[2] ^ v[0].d[3] ^ v[0].d[4] ^ v[0].d[5]);
    commit = 1;
    tick();
    commit = 0;
    repeat (4) tick();
    chk("mid_we_before_rst", int'(cfg_we), 1);
    chk("mid_addr_before_rst", int'(cfg_addr), 2);
    #2 rst = 1;
    #1;
    chk("mid_rst_cfg_we", int'(cfg_we), 0);
    chk("mid_rst_cfg_addr", int'(cfg_addr), 0);
    chk("mid_rst_wght_data", int'(wght_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_host_ready", int'(host_ready), 1);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_err", int'(err), 0);
    @(negedge clk);
    rst = 0;
    tick();
    commit = 1;
    tick();
    commit = 0;
    tick();
    tick();
    chk("post_rst_shadow_cleared_err", int'(err), 1);
    chk("post_rst_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cfg_sequencer.md
# cfg_sequencer

Host-side configuration sequencer for the driver-monitor datapath. It buffers a full parameter set (four ML weights plus the warning and emergency thresholds) in shadow registers through a valid/ready host port. On `commit` it validates the set and waits until the safety path is not in emergency. It then streams the set into the configuration register file as an atomic burst of `cfg_we`/`cfg_addr`/`wght_data` writes, so the ML pipeline never sees a half-updated weight set.

## Interface
- `NUM_REGS`, 6: shadow words streamed per burst; fixed map is addr 0..3 = w0..w3 (data[7:0], signed), addr 4 = warn_th (data[7:0]), addr 5 = emer_th (data[7:0]).
- `TIMEOUT`, 255: max cycles spent in WAIT_SAFE before erroring; 8-bit counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_valid`  in  1  host write request.
- `host_ready`  out  1  high only in IDLE; a write transfers when `host_valid && host_ready`.
- `host_idx`  in  3  shadow index of the host write.
- `host_data`  in  16  host write data.
- `commit`  in  1  start a validate-and-burst; sampled in IDLE only.
- `abort`  in  1  cancel while in WAIT_SAFE.
- `emergency`  in  1  safety-FSM emergency flag; while high, no burst may start.
- `cfg_we`  out  1  config write strobe.
- `cfg_addr`  out  4  config address.
- `wght_data`  out  16  config write data.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after a completed burst.
- `err`  out  2  00 ok, 01 threshold order, 10 safe-wait timeout, 11 checksum mismatch.

## Operation
- States are IDLE, CHECK, WAIT_SAFE, WRITE, DONE and ERR.
- **IDLE:** accepts host writes into shadow[host_idx].
  - Writes with idx ≥ NUM_REGS are acknowledged and discarded, except idx 6 when checksum is compiled in.
  - `commit`=1 moves to CHECK.
  - A host write in the same cycle as `commit` is captured first and is included in the set.
- **CHECK (1 cycle):** passes if shadow[4][7:0] < shadow[5][7:0], unsigned.
  - Pass goes to WAIT_SAFE with the timeout counter cleared.
  - Fail goes to ERR with err=01.
- **WAIT_SAFE:**
  - `abort`=1 goes to IDLE with no writes; err=00. Abort has priority over the other exits.
  - Else `emergency`=0 goes to WRITE with the word counter = 0.
  - Else the counter increments; when it reaches TIMEOUT, go to ERR with err=10.
- **WRITE:**
  - Each cycle drives cfg_we=1, cfg_addr=counter, wght_data=shadow[counter].
  - After counter NUM_REGS-1, go to DONE.
  - `abort`, `emergency` and `commit` are ignored; the burst is atomic.
- **DONE:** done=1 for one cycle, then IDLE.
- **ERR:** one cycle, then IDLE.
- **err:** latched; holds its value until the next `commit` accepted in IDLE clears it.
- **Idle outputs:** outside WRITE, cfg_we=0, cfg_addr=0 and wght_data=0.
- **Shadow persistence:** shadow contents persist across bursts and errors. Only the host port or reset changes them.

## Timing
- **Reset values:** state=IDLE, every shadow word 0, counters 0, host_ready=1, busy=0, done=0, err=00, cfg_we=0, cfg_addr=0, wght_data=0.
- **Burst timing, for `commit` sampled at edge N with emergency low:**
  - CHECK in cycle N+1.
  - WAIT_SAFE in N+2.
  - cfg_we high in cycles N+3..N+8, with addr 0..5.
  - done high in N+9.
  - host_ready high again in N+10.
- **Emergency held:** each cycle emergency stays high in WAIT_SAFE delays the first write by one cycle.
- **Timeout:** with emergency stuck high, err=10 and the ERR state occur TIMEOUT cycles after WAIT_SAFE entry.
- **Reset mid-burst:** returns to the reset values immediately.
  - Shadow is cleared and cfg_we drops asynchronously.
  - Downstream config may then hold a partial set; the host must re-commit.
- **Outputs:** all outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `CFG_SEQ_CHECKSUM_EN`.
- **Defined:**
  - host_idx 6 writes a checksum register (reset 0).
  - CHECK first tests that the XOR of shadow[0..5] equals the checksum; a mismatch goes to ERR with err=11.
  - The threshold-order test runs only when the checksum matches.
- **Undefined:**
  - idx 6 is discarded like any other out-of-range index.
  - err=11 never occurs.
  - The timing is identical in both builds.

## Test plan
- **Basic burst:** write w0..w3 = 0x0005, 0x00FE, 0x0010, 0x0003, warn = 0x0040, emer = 0x0080, then commit with emergency=0.
  - Expect six cfg_we cycles with addr 0..5 carrying exactly that data, starting 3 cycles after commit.
  - done pulses once and err=00.
- **Threshold order:** warn = 0x0080, emer = 0x0040, then commit.
  - Expect no cfg_we, err=01 and busy=0 three cycles after commit.
- **Safe wait:** hold emergency=1 for 10 cycles after WAIT_SAFE entry.
  - Expect the first cfg_we 10 cycles later than the basic case.
  - With emergency held permanently, expect err=10 after 255 cycles and no writes.
- **Abort and mid-burst emergency:** abort in WAIT_SAFE returns to IDLE with no writes and err=00; emergency rising in the 2nd WRITE cycle still yields all 6 writes.
- **Collisions and reset:**
  - A commit sharing a cycle with a host write to idx 5 must burst the new emer value.
  - A reset asserted in the 3rd WRITE cycle drops cfg_we immediately, and all outputs take their reset values.
- **Checksum build (`CFG_SEQ_CHECKSUM_EN` defined):**
  - A wrong checksum gives err=11 and no writes.
  - The correct XOR bursts normally.
